// File: rtl/mult_bist_driver.sv
// Exhaustive self-test driver for an OP_W x OP_W array multiplier: sweeps every {B,A} pair and checks each product.
// Optional build macro MULT_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module mult_bist_driver #(
  parameter int OP_W  = 4,
  parameter int LAT   = 1,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  output logic [2*OP_W-1:0] dut_ui,
  input  logic [2*OP_W-1:0] dut_uo,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [2*OP_W-1:0] first_fail
);

  localparam int         VW    = 2 * OP_W;
  localparam logic [2:0] LAT_L = 3'(LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [VW-1:0]    r_operand;
  logic [2:0]       r_wait_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_count;
  logic [VW-1:0]    r_first_fail;
  logic             r_ff_seen;

  logic [OP_W-1:0]  w_op_a;
  logic [OP_W-1:0]  w_op_b;
  logic [VW-1:0]    w_expected;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_inc;
  logic [ERR_W-1:0] w_err_after;
  logic             w_last;
  logic             w_stop;

  assign w_op_a     = r_operand[OP_W-1:0];
  assign w_op_b     = r_operand[VW-1:OP_W];
  // Zero-extend both operands so the reference product keeps all 2*OP_W bits.
  assign w_expected = {{OP_W{1'b0}}, w_op_a} * {{OP_W{1'b0}}, w_op_b};
  assign w_mismatch = (dut_uo != w_expected);
  assign w_err_inc  = (&r_err_count) ? r_err_count : r_err_count + ERR_W'(1);
  assign w_err_after = w_mismatch ? w_err_inc : r_err_count;
  assign w_last     = &r_operand;

`ifdef MULT_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // NOTE: every state register uses non-blocking assignments so all of them
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_operand    <= '0;
      r_wait_cnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_first_fail <= '0;
      r_ff_seen    <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_ff_seen    <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_operand    <= '0;
            r_wait_cnt   <= LAT_L;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) r_state <= S_CHECK;
          else                  r_wait_cnt <= r_wait_cnt - 3'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err_count <= w_err_inc;
            if (!r_ff_seen) begin
              r_first_fail <= r_operand;
              r_ff_seen    <= 1'b1;
            end
          end
          // Operand stays on its last value in DONE, so it never wraps.
          if (w_last || w_stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_after == '0);
          end else begin
            r_operand  <= r_operand + VW'(1);
            r_wait_cnt <= LAT_L;
            r_state    <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_ui     = r_operand;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_mult_bist_driver.sv
// Bench for mult_bist_driver: a LAT=1/ERR_W=8 and a LAT=0/ERR_W=4 instance share stimulus and faulty multiplier models.
// Expected results come from a per-vector sweep of the multiplier model against plain a*b arithmetic.
module tb_mult_bist_driver;

  localparam int NV = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] ui_a, uo_a, ff_a, err_a;
  logic [7:0] ui_b, uo_b, ff_b;
  logic [3:0] err_b;
  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;

  int         mode;
  logic [7:0] fault_mask [NV];
  int         n_checks;
  int         n_errors;

  always #5 clk = ~clk;

  // Multiplier model: 0 = correct, 1 = product bit0 stuck at 0, 2 = per-vector XOR fault table.
  function automatic logic [7:0] model_out(input logic [7:0] v, input int md, input logic [7:0] fm);
    int p;
    p = int'(v[3:0]) * int'(v[7:4]);
    case (md)
      1:       p = p & 'hFE;
      2:       p = p ^ int'(fm);
      default: ;
    endcase
    return 8'(p);
  endfunction

  always @(posedge clk) uo_a <= model_out(ui_a, mode, fault_mask[ui_a]);
  assign uo_b = model_out(ui_b, mode, fault_mask[ui_b]);

  mult_bist_driver #(.OP_W(4), .LAT(1), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_ui(ui_a), .dut_uo(uo_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
  );

  mult_bist_driver #(.OP_W(4), .LAT(0), .ERR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_ui(ui_b), .dut_uo(uo_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Walk all vectors in sweep order: n_vec vectors visited, raw mismatch count, first failing {B,A}.
  function automatic void ref_sweep(input int md, output int n_vec, output int raw, output int ff);
    int a, b, got;
    n_vec = NV;
    raw   = 0;
    ff    = 0;
    for (int v = 0; v < NV; v++) begin
      a   = v % 16;
      b   = v / 16;
      got = int'(model_out(8'(v), md, fault_mask[v]));
      if (got != a * b) begin
        if (raw == 0) ff = v;
        raw++;
`ifdef MULT_BIST_STOP_ON_FAIL_EN
        n_vec = v + 1;
        break;
`endif
      end
    end
  endfunction

  function automatic int sat(input int raw, input int w);
    return (raw > (1 << w) - 1) ? (1 << w) - 1 : raw;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "/ui_a"}, ui_a, 0);
    check({tag, "/busy_a"}, busy_a, 0);
    check({tag, "/done_a"}, done_a, 0);
    check({tag, "/pass_a"}, pass_a, 0);
    check({tag, "/err_a"}, err_a, 0);
    check({tag, "/ff_a"}, ff_a, 0);
    check({tag, "/ui_b"}, ui_b, 0);
    check({tag, "/busy_b"}, busy_b, 0);
    check({tag, "/done_b"}, done_b, 0);
    check({tag, "/err_b"}, err_b, 0);
    check({tag, "/ff_b"}, ff_b, 0);
  endtask

  // pause_kind: 0 none, 1 ten idle cycles from edge 201, 2 random ena.
  task automatic sweep(input string tag, input int md, input int pause_kind, input bit extra_start);
    int nv, raw, ff;
    int edges, active, act_a, act_b, cyc_a;
    bit got_a, got_b;
    logic [7:0] snap_ui, snap_err;
    ref_sweep(md, nv, raw, ff);
    mode  = md;
    edges = 0; active = 0; act_a = 0; act_b = 0; cyc_a = 0;
    got_a = 1'b0; got_b = 1'b0;
    snap_ui = '0; snap_err = '0;
    @(negedge clk);
    ena   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "/busy_a_on"}, busy_a, 1);
    check({tag, "/busy_b_on"}, busy_b, 1);
    check({tag, "/done_a_clr"}, done_a, 0);
    check({tag, "/err_a_clr"}, err_a, 0);
    check({tag, "/ff_b_clr"}, ff_b, 0);
    while (!(got_a && got_b) && edges < 4000) begin
      case (pause_kind)
        1:       ena = !(edges >= 200 && edges < 210);
        2:       ena = ($urandom_range(0, 5) != 0);
        default: ena = 1'b1;
      endcase
      if (extra_start) start = (edges == 50);
      if (pause_kind == 1 && edges == 200) begin
        snap_ui  = ui_a;
        snap_err = err_a;
      end
      if (pause_kind == 1 && edges == 210) begin
        check({tag, "/frozen_ui"}, ui_a, snap_ui);
        check({tag, "/frozen_err"}, err_a, snap_err);
        check({tag, "/frozen_busy"}, busy_a, 1);
      end
      @(negedge clk);
      edges++;
      if (ena) active++;
      if (!got_a && done_a) begin got_a = 1'b1; act_a = active; cyc_a = edges; end
      if (!got_b && done_b) begin got_b = 1'b1; act_b = active; end
    end
    ena   = 1'b1;
    start = 1'b0;
    check({tag, "/done_a_seen"}, got_a, 1);
    check({tag, "/done_b_seen"}, got_b, 1);
    check({tag, "/len_a"}, act_a, nv * 3);
    check({tag, "/len_b"}, act_b, nv * 2);
    if (pause_kind == 1) check({tag, "/cycles_a"}, cyc_a, nv * 3 + 10);
    if (pause_kind == 0) check({tag, "/cycles_a"}, cyc_a, nv * 3);
    check({tag, "/pass_a"}, pass_a, (raw == 0) ? 1 : 0);
    check({tag, "/pass_b"}, pass_b, (raw == 0) ? 1 : 0);
    check({tag, "/err_a"}, err_a, sat(raw, 8));
    check({tag, "/err_b"}, err_b, sat(raw, 4));
    check({tag, "/ff_a"}, ff_a, ff);
    check({tag, "/ff_b"}, ff_b, ff);
    check({tag, "/busy_a_off"}, busy_a, 0);
    check({tag, "/busy_b_off"}, busy_b, 0);
  endtask

  task automatic reset_mid_sweep();
    mode = 1;
    @(negedge clk);
    ena   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    check("pre_rst/busy_a", busy_a, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_zero("post_rst_idle");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ena   = 1'b0;
    start = 1'b0;
    mode  = 0;
    for (int v = 0; v < NV; v++) fault_mask[v] = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle/busy_a", busy_a, 0);

    sweep("correct", 0, 0, 1'b1);
    sweep("stuck0", 1, 0, 1'b0);
    sweep("pause", 0, 1, 1'b0);
    reset_mid_sweep();
    sweep("after_rst", 0, 0, 1'b0);
    sweep("rerun_stuck", 1, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < NV; v++)
        fault_mask[v] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      sweep($sformatf("rand%0d", r), 2, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
